// File: rtl/led_share_arbiter_if.sv
// led_share_arbiter_if: pattern-source requests in, LED drive and grant status out
interface led_share_arbiter_if #(parameter int N_REQ = 4);
  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] pat;
  logic               fault;
  logic [7:0]         leds;
  logic [N_REQ-1:0]   gnt;
  logic               gnt_new;
  modport master (output req, pat, fault, input leds, gnt, gnt_new);
  modport slave (input req, pat, fault, output leds, gnt, gnt_new);
endinterface

// File: rtl/led_share_arbiter.sv
// led_share_arbiter: round-robin LED time-sharing with minimum dwell and fault blink override
module led_share_arbiter #(
  parameter int         N_REQ      = 4,
  parameter int         DWELL      = 125000000,
  parameter int         BLINK_HALF = 31250000,
  parameter logic [7:0] IDLE_PAT   = 8'h00
) (
  input logic                clk,
  input logic                rst,
  led_share_arbiter_if.slave bus
);
  localparam int PW = $clog2(N_REQ);
  localparam int DW = $clog2(DWELL);
  localparam int BW = BLINK_HALF > 1 ? $clog2(BLINK_HALF) : 1;
  typedef enum logic [1:0] {IDLE, HOLD, FAULT} state_t;
  state_t          state, state_nxt;
  logic [DW-1:0]   dwell_cnt, dwell_nxt;
  logic [BW-1:0]   blink_cnt, blink_nxt;
  logic            blink_ph, ph_nxt;
  logic [PW-1:0]   rr_ptr, ptr_nxt, pick, cand;
  logic [7:0]      leds, leds_nxt;
  logic [N_REQ-1:0] gnt, gnt_nxt;
  logic            gnt_new, gnt_new_nxt;
  logic            found, lost, dwell_end, rearb, sw, keep, last_ph;
  logic [7:0]      pats [N_REQ];
  int              idx;
  assign bus.leds    = leds;
  assign bus.gnt     = gnt;
  assign bus.gnt_new = gnt_new;
  assign lost      = !bus.req[rr_ptr];
  assign dwell_end = dwell_cnt == DW'(DWELL - 1);
  assign rearb     = state == IDLE || (state == HOLD && (lost || dwell_end));
  // unpack the per-source pattern bus and find the first requester after rr_ptr (lowest offset wins)
  always_comb begin
    found = 1'b0;
    pick  = rr_ptr;
    cand  = rr_ptr;
    idx   = 0;
    for (int i = 0; i < N_REQ; i++) pats[i] = bus.pat[8*i +: 8];
    for (int k = N_REQ; k >= 1; k--) begin
      idx  = int'(rr_ptr) + k;
      idx  = idx >= N_REQ ? idx - N_REQ : idx;
      cand = PW'(idx);
      if (bus.req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end
  // state register plus all registered outputs and counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      dwell_cnt <= '0;
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
      rr_ptr    <= PW'(N_REQ - 1);
      leds      <= IDLE_PAT;
      gnt       <= '0;
      gnt_new   <= 1'b0;
    end else begin
      state     <= state_nxt;
      dwell_cnt <= dwell_nxt;
      blink_cnt <= blink_nxt;
      blink_ph  <= ph_nxt;
      rr_ptr    <= ptr_nxt;
      leds      <= leds_nxt;
      gnt       <= gnt_nxt;
      gnt_new   <= gnt_new_nxt;
    end
  end
  // next state: fault wins, fault release goes idle, rearbitration decides hold vs idle
  always_comb begin
    state_nxt = bus.fault ? FAULT : state == FAULT ? IDLE : rearb ? (found ? HOLD : IDLE) : HOLD;
  end
  // next values of grant, LEDs, dwell and blink counters
  always_comb begin
    sw          = !bus.fault && rearb && found && (state == IDLE || pick != rr_ptr);
    keep        = state == HOLD && !lost;
    last_ph     = blink_cnt == BW'(BLINK_HALF - 1);
    ph_nxt      = bus.fault && (state != FAULT || (last_ph ? !blink_ph : blink_ph));
    blink_nxt   = bus.fault && state == FAULT && !last_ph ? blink_cnt + BW'(1) : '0;
    leds_nxt    = bus.fault ? (ph_nxt ? 8'hFF : 8'h00) : state == HOLD && (!lost || found) ? pats[rr_ptr] : IDLE_PAT;
    gnt_nxt     = bus.fault ? '0 : sw ? N_REQ'(1) << pick : keep ? gnt : '0;
    gnt_new_nxt = sw;
    ptr_nxt     = sw ? pick : rr_ptr;
    dwell_nxt   = bus.fault || sw || state != HOLD || dwell_end ? '0 : dwell_cnt + DW'(1);
  end
endmodule

// File: tb/tb_led_share_arbiter.sv
// tb_led_share_arbiter: directed scenarios plus random traffic against a grant-age/fault-time model
module tb_led_share_arbiter;
  localparam int N = 4, DW = 8, BH = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;
  led_share_arbiter_if #(.N_REQ(N)) bus ();
  led_share_arbiter #(.N_REQ(N), .DWELL(DW), .BLINK_HALF(BH), .IDLE_PAT(8'h00)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  int m_owner, m_last, m_age, m_fc, m_pick;
  bit m_in_fault, m_new;
  logic [7:0] m_leds;

  function automatic int next_req(input int from, input int span);
    for (int k = 1; k <= span; k++) if (bus.req[(from + k) % N]) return (from + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] m_gnt();
    return m_owner < 0 ? '0 : N'(1) << m_owner;
  endfunction

  // model: owner index, cycles owned, cycles spent in fault
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_owner = -1; m_last = N - 1; m_age = 0; m_fc = 0; m_in_fault = 0; m_new = 0; m_leds = 8'h00;
    end else begin
      m_new = 0;
      if (bus.fault) begin
        m_fc = m_in_fault ? m_fc + 1 : 0;
        m_in_fault = 1; m_owner = -1;
        m_leds = ((m_fc / BH) % 2 == 0) ? 8'hFF : 8'h00;
      end else if (m_in_fault) begin
        m_in_fault = 0; m_owner = -1; m_leds = 8'h00;
      end else if (m_owner < 0 || !bus.req[m_owner]) begin
        m_leds = m_owner < 0 ? 8'h00 : bus.pat[8*m_owner +: 8];
        m_pick = next_req(m_last, N);
        if (m_pick < 0) begin
          m_owner = -1; m_leds = 8'h00;
        end else begin
          m_owner = m_pick; m_last = m_pick; m_age = 1; m_new = 1;
        end
      end else begin
        m_leds = bus.pat[8*m_owner +: 8];
        if (m_age == DW) begin
          m_pick = next_req(m_last, N - 1);
          if (m_pick < 0) m_age = 1;
          else begin
            m_owner = m_pick; m_last = m_pick; m_age = 1; m_new = 1;
          end
        end else m_age++;
      end
    end
  end

  task automatic test_reset();
    rst = 1'b0; bus.req = '0; bus.pat = '0; bus.fault = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.leds, bus.gnt, bus.gnt_new} !== 13'h0) begin
      failures++; $display("FAIL reset_state leds=%h gnt=%b gnt_new=%b want 00/0000/0", bus.leds, bus.gnt, bus.gnt_new);
    end
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (bus.leds !== 8'h00 || bus.gnt !== 4'h0 || bus.gnt_new !== 1'b0) begin
        failures++; $display("FAIL idle_no_req cyc=%0d leds=%h gnt=%b want 00/0000", i, bus.leds, bus.gnt);
      end
    end
    bus.req = 4'b0010; bus.pat[15:8] = 8'hA5;
    @(negedge clk);
    checks++;
    if (bus.gnt !== 4'b0010 || bus.gnt_new !== 1'b1 || bus.leds !== 8'h00) begin
      failures++; $display("FAIL first_grant gnt=%b new=%b leds=%h want 0010/1/00", bus.gnt, bus.gnt_new, bus.leds);
    end
    @(negedge clk);
    checks++;
    if (bus.gnt !== 4'b0010 || bus.gnt_new !== 1'b0 || bus.leds !== 8'hA5) begin
      failures++; $display("FAIL first_leds gnt=%b new=%b leds=%h want 0010/0/a5", bus.gnt, bus.gnt_new, bus.leds);
    end
  endtask

  task automatic test_rotation();
    logic [N-1:0] seq[$];
    int at[$];
    bus.req = 4'b1011; bus.pat = 32'h4433A511;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.leds, bus.gnt, bus.gnt_new} !== {m_leds, m_gnt(), m_new}) begin
        failures++; $display("FAIL rotation_model cyc=%0d got %h/%b/%b want %h/%b/%b", c, bus.leds, bus.gnt, bus.gnt_new, m_leds, m_gnt(), m_new);
      end
      if (bus.gnt_new) begin seq.push_back(bus.gnt); at.push_back(c); end
    end
    checks++;
    if (seq.size() < 3 || seq[0] !== 4'b1000 || seq[1] !== 4'b0001 || seq[2] !== 4'b0010) begin
      failures++; $display("FAIL rotation_order n=%0d got %b,%b,%b want 1000,0001,0010", seq.size(), seq[0], seq[1], seq[2]);
    end
    checks++;
    if (seq.size() < 3 || at[1] - at[0] != DW || at[2] - at[1] != DW) begin
      failures++; $display("FAIL rotation_dwell spans %0d,%0d want %0d", at[1] - at[0], at[2] - at[1], DW);
    end
  endtask

  task automatic test_single();
    logic [7:0] prev;
    int pulses = 0;
    bus.req = '0;
    repeat (2) @(negedge clk);
    bus.req = 4'b0001; prev = 8'h00;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      checks++;
      if (bus.gnt !== 4'b0001 || (c >= 1 && bus.leds !== prev)) begin
        failures++; $display("FAIL single_hold cyc=%0d gnt=%b leds=%h want 0001/%h", c, bus.gnt, bus.leds, prev);
      end
      pulses += int'(bus.gnt_new);
      prev = 8'($urandom);
      bus.pat[7:0] = prev;
    end
    checks++;
    if (pulses != 1) begin
      failures++; $display("FAIL single_pulses got %0d want 1", pulses);
    end
  endtask

  task automatic test_drop();
    bit seen = 0;
    bus.req = 4'b1100;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      seen = bus.gnt === 4'b0100;
    end
    checks++;
    if (!seen) begin
      failures++; $display("FAIL drop_wait gnt=%b want 0100 within 20 cycles", bus.gnt);
    end
    repeat (3) @(negedge clk);
    bus.req = 4'b1000;
    @(negedge clk);
    checks++;
    if (bus.gnt !== 4'b1000 || bus.gnt_new !== 1'b1) begin
      failures++; $display("FAIL drop_regrant gnt=%b new=%b want 1000/1", bus.gnt, bus.gnt_new);
    end
    bus.req = '0;
    @(negedge clk);
    checks++;
    if (bus.gnt !== 4'b0000 || bus.leds !== 8'h00 || bus.gnt_new !== 1'b0) begin
      failures++; $display("FAIL drop_all gnt=%b leds=%h want 0000/00", bus.gnt, bus.leds);
    end
  endtask

  task automatic test_fault();
    logic [7:0] want;
    bus.req = 4'b0011; bus.pat = 32'h12345678;
    repeat (3) @(negedge clk);
    bus.fault = 1'b1;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      want = ((j / BH) % 2 == 0) ? 8'hFF : 8'h00;
      checks++;
      if (bus.leds !== want || bus.gnt !== 4'h0 || bus.gnt_new !== 1'b0) begin
        failures++; $display("FAIL fault_blink j=%0d leds=%h gnt=%b want %h/0000", j, bus.leds, bus.gnt, want);
      end
    end
    bus.fault = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.leds !== 8'h00 || bus.gnt !== 4'h0) begin
      failures++; $display("FAIL fault_exit leds=%h gnt=%b want 00/0000", bus.leds, bus.gnt);
    end
    @(negedge clk);
    checks++;
    if (bus.gnt !== m_gnt() || bus.gnt === 4'h0 || bus.gnt_new !== 1'b1) begin
      failures++; $display("FAIL fault_rearb gnt=%b new=%b want %b/1", bus.gnt, bus.gnt_new, m_gnt());
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.leds, bus.gnt, bus.gnt_new} !== {m_leds, m_gnt(), m_new}) begin
        failures++; $display("FAIL random_model cyc=%0d got %h/%b/%b want %h/%b/%b", c, bus.leds, bus.gnt, bus.gnt_new, m_leds, m_gnt(), m_new);
      end
      if ($urandom_range(0, 5) == 0) bus.req = 4'($urandom);
      if ($urandom_range(0, 40) == 0) bus.fault = ~bus.fault;
      bus.pat = $urandom;
    end
    bus.fault = 1'b0;
  endtask

  task automatic test_async_reset();
    bus.req = 4'b0110;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #3;
    checks++;
    if (bus.gnt === 4'h0) begin
      failures++; $display("FAIL areset_pre gnt=%b want nonzero", bus.gnt);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.leds !== 8'h00 || bus.gnt !== 4'h0 || bus.gnt_new !== 1'b0) begin
      failures++; $display("FAIL areset_now leds=%h gnt=%b new=%b want 00/0000/0", bus.leds, bus.gnt, bus.gnt_new);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.gnt !== 4'b0010 || bus.gnt_new !== 1'b1) begin
      failures++; $display("FAIL areset_first gnt=%b new=%b want 0010/1", bus.gnt, bus.gnt_new);
    end
  endtask

  initial begin
    bus.req = '0; bus.pat = '0; bus.fault = 1'b0;
    test_reset();
    test_rotation();
    test_single();
    test_drop();
    test_fault();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
